// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker for an in-order issue stage.
// Holds decode while a source is still awaiting writeback or a destination
// already has the maximum number of writes in flight. Register 0 is hard-wired zero.
module reg_scoreboard #(
   parameter int NREG    = 32,
   parameter int MAXPEND = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [4:0]      issue_ra1,
   input  logic [4:0]      issue_ra2,
   input  logic            issue_use1,
   input  logic            issue_use2,
   input  logic            issue_wen,
   input  logic [4:0]      issue_dst,
   output logic            issue_ready,
   input  logic            wb_valid,
   input  logic [4:0]      wb_dst,
   input  logic            flush,
   output logic [NREG-1:0] busy,
   output logic [31:0]     stall_cycles,
   output logic            wb_err
);

   localparam logic [1:0] MAX_CNT = 2'(MAXPEND);

   logic [1:0]      cnt_q [NREG];
   logic [1:0]      cnt_d [NREG];
   logic [31:0]     stall_q, stall_d;
   logic            wb_err_q, wb_err_d;

   logic [1:0]      cnt_ra1, cnt_ra2, cnt_dst, cnt_wb;
   logic            raw_hazard, waw_hazard, fire;
   logic            wb_hit, wb_bad;
   logic [NREG-1:0] inc_sel, dec_sel;

   // Register 0 and addresses beyond NREG always read as "nothing pending".
   function automatic logic [1:0] cnt_of(input logic [4:0] a);
      cnt_of = 2'b00;
      if (a != 5'd0 && int'(a) < NREG) cnt_of = cnt_q[a];
   endfunction

   // Hazard detection from registered counts only, so a same-cycle writeback never unblocks.
   always_comb begin
      cnt_ra1     = cnt_of(issue_ra1);
      cnt_ra2     = cnt_of(issue_ra2);
      cnt_dst     = cnt_of(issue_dst);
      cnt_wb      = cnt_of(wb_dst);
      raw_hazard  = (issue_use1 && cnt_ra1 != 2'b00) || (issue_use2 && cnt_ra2 != 2'b00);
      waw_hazard  = issue_wen && issue_dst != 5'd0 && cnt_dst == MAX_CNT;
      issue_ready = !raw_hazard && !waw_hazard && !flush;
      fire        = issue_valid && issue_ready;
      wb_hit      = wb_valid && wb_dst != 5'd0 && cnt_wb != 2'b00;
      wb_bad      = wb_valid && wb_dst != 5'd0 && cnt_wb == 2'b00 && !flush;
   end

   // Next pending counts: an increment and decrement on the same register cancel; flush clears all.
   always_comb begin
      inc_sel = '0;
      dec_sel = '0;
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      for (int i = 1; i < NREG; i++) begin
         inc_sel[i] = fire && issue_wen && issue_dst == 5'(i) && cnt_q[i] != MAX_CNT;
         dec_sel[i] = wb_hit && wb_dst == 5'(i);
         if (flush) begin
            cnt_d[i] = 2'b00;
         end else if (inc_sel[i] && !dec_sel[i]) begin
            cnt_d[i] = cnt_q[i] + 2'b01;
         end else if (dec_sel[i] && !inc_sel[i]) begin
            cnt_d[i] = cnt_q[i] - 2'b01;
         end
      end
      cnt_d[0] = 2'b00;
   end

   // Saturating stall counter and sticky bad-writeback flag.
   always_comb begin
      stall_d  = stall_q;
      wb_err_d = wb_err_q || wb_bad;
      if (issue_valid && !issue_ready && !flush && stall_q != 32'hFFFF_FFFF) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Busy vector straight from registered counts.
   always_comb begin
      busy = '0;
      for (int i = 1; i < NREG; i++) begin
         busy[i] = cnt_q[i] != 2'b00;
      end
   end

   assign stall_cycles = stall_q;
   assign wb_err       = wb_err_q;

   // State registers with synchronous active-low reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= 2'b00;
         end
         stall_q  <= '0;
         wb_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stall_q  <= stall_d;
         wb_err_q <= wb_err_d;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vector table plus hand-written multi-cycle sequences.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_use1, issue_use2, issue_wen;
   logic [4:0]  issue_ra1, issue_ra2, issue_dst;
   logic        issue_ready;
   logic        wb_valid;
   logic [4:0]  wb_dst;
   logic        flush;
   logic [31:0] busy;
   logic [31:0] stall_cycles;
   logic        wb_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        valid;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        use1;
      logic        use2;
      logic        wen;
      logic [4:0]  dst;
      logic        wbv;
      logic [4:0]  wbd;
      logic        flush;
      logic        expReady;
      logic [31:0] expBusy;
      logic [31:0] expStall;
      logic        expErr;
   } vec_t;

   vec_t vecs[14];

   reg_scoreboard #(.NREG(32), .MAXPEND(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_ra1    (issue_ra1),
      .issue_ra2    (issue_ra2),
      .issue_use1   (issue_use1),
      .issue_use2   (issue_use2),
      .issue_wen    (issue_wen),
      .issue_dst    (issue_dst),
      .issue_ready  (issue_ready),
      .wb_valid     (wb_valid),
      .wb_dst       (wb_dst),
      .flush        (flush),
      .busy         (busy),
      .stall_cycles (stall_cycles),
      .wb_err       (wb_err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic applyStimulus(input vec_t v);
      issue_valid = v.valid;
      issue_ra1   = v.ra1;
      issue_ra2   = v.ra2;
      issue_use1  = v.use1;
      issue_use2  = v.use2;
      issue_wen   = v.wen;
      issue_dst   = v.dst;
      wb_valid    = v.wbv;
      wb_dst      = v.wbd;
      flush       = v.flush;
   endtask

   task automatic clearInputs();
      issue_valid = 1'b0;
      issue_ra1   = 5'd0;
      issue_ra2   = 5'd0;
      issue_use1  = 1'b0;
      issue_use2  = 1'b0;
      issue_wen   = 1'b0;
      issue_dst   = 5'd0;
      wb_valid    = 1'b0;
      wb_dst      = 5'd0;
      flush       = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Main directed test.
   initial begin
      // Rows: valid ra1 ra2 use1 use2 wen dst wbv wbd flush | ready busy stall err
      vecs[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,  32'd0, 1'b0};
      vecs[1]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,  32'd0, 1'b0};
      vecs[2]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 32'd0, 1'b0};
      vecs[3]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 32'd1, 1'b0};
      vecs[4]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h20, 32'd2, 1'b0};
      vecs[5]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,  32'd3, 1'b0};
      vecs[6]  = '{1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,  32'd3, 1'b0};
      vecs[7]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,  32'd3, 1'b0};
      vecs[8]  = '{1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h20, 32'd3, 1'b0};
      vecs[9]  = '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 32'd3, 1'b0};
      vecs[10] = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 32'd4, 1'b0};
      vecs[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 32'h20, 32'd4, 1'b0};
      vecs[12] = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 32'h0,  32'd4, 1'b0};
      vecs[13] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0,  32'd4, 1'b0};

      clearInputs();
      reset = 1'b0;
      @(posedge clk);
      tick();
      reset = 1'b1;
      #1;
      checkOutput("reset ready", 32'(issue_ready), 32'd1);
      checkOutput("reset busy",  busy,             32'h0);
      checkOutput("reset stall", stall_cycles,     32'd0);
      checkOutput("reset err",   32'(wb_err),      32'd0);

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("row%0d ready", i), 32'(issue_ready), 32'(vecs[i].expReady));
         checkOutput($sformatf("row%0d busy", i),  busy,             vecs[i].expBusy);
         checkOutput($sformatf("row%0d stall", i), stall_cycles,     vecs[i].expStall);
         checkOutput($sformatf("row%0d err", i),   32'(wb_err),      32'(vecs[i].expErr));
         tick();
      end

      // WAW limit on register 7.
      clearInputs();
      issue_valid = 1'b1;
      issue_wen   = 1'b1;
      issue_dst   = 5'd7;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput($sformatf("waw fire%0d ready", k), 32'(issue_ready), 32'd1);
         tick();
      end
      #1;
      checkOutput("waw full ready", 32'(issue_ready), 32'd0);
      checkOutput("waw full busy",  busy,             32'h80);
      tick();
      wb_valid = 1'b1;
      wb_dst   = 5'd7;
      #1;
      checkOutput("waw same-cycle wb ready", 32'(issue_ready), 32'd0);
      tick();
      wb_valid = 1'b0;
      #1;
      checkOutput("waw fourth ready", 32'(issue_ready), 32'd1);
      tick();
      #1;
      checkOutput("waw back to 3 ready", 32'(issue_ready), 32'd0);
      checkOutput("waw stall",           stall_cycles,     32'd6);
      clearInputs();
      wb_valid = 1'b1;
      wb_dst   = 5'd7;
      repeat (3) tick();
      clearInputs();
      #1;
      checkOutput("waw drained busy", busy,        32'h0);
      checkOutput("waw drained err",  32'(wb_err), 32'd0);

      // Simultaneous fire and writeback on register 9.
      issue_valid = 1'b1;
      issue_wen   = 1'b1;
      issue_dst   = 5'd9;
      tick();
      wb_valid = 1'b1;
      wb_dst   = 5'd9;
      #1;
      checkOutput("simul ready", 32'(issue_ready), 32'd1);
      tick();
      clearInputs();
      #1;
      checkOutput("simul busy", busy, 32'h200);
      wb_valid = 1'b1;
      wb_dst   = 5'd9;
      tick();
      clearInputs();
      #1;
      checkOutput("simul drained busy", busy,        32'h0);
      checkOutput("simul drained err",  32'(wb_err), 32'd0);

      // Writes to x0 never accumulate or stall.
      issue_valid = 1'b1;
      issue_wen   = 1'b1;
      issue_dst   = 5'd0;
      issue_use1  = 1'b1;
      issue_ra1   = 5'd0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("x0 fire%0d ready", k), 32'(issue_ready), 32'd1);
         tick();
      end
      clearInputs();
      #1;
      checkOutput("x0 busy", busy, 32'h0);

      // Writeback to a register with nothing pending is a sticky error.
      wb_valid = 1'b1;
      wb_dst   = 5'd12;
      tick();
      clearInputs();
      #1;
      checkOutput("err set",  32'(wb_err), 32'd1);
      checkOutput("err busy", busy,        32'h0);
      repeat (2) tick();
      checkOutput("err sticky", 32'(wb_err), 32'd1);

      // Flush with pending registers and a concurrent issue.
      for (int d = 3; d <= 5; d++) begin
         issue_valid = 1'b1;
         issue_wen   = 1'b1;
         issue_dst   = 5'(d);
         tick();
      end
      clearInputs();
      #1;
      checkOutput("flush pre busy", busy, 32'h38);
      issue_valid = 1'b1;
      issue_wen   = 1'b1;
      issue_dst   = 5'd6;
      flush       = 1'b1;
      #1;
      checkOutput("flush ready", 32'(issue_ready), 32'd0);
      tick();
      clearInputs();
      #1;
      checkOutput("flush busy",  busy,         32'h0);
      checkOutput("flush stall", stall_cycles, 32'd6);

      // Reset in the middle of activity.
      issue_valid = 1'b1;
      issue_wen   = 1'b1;
      issue_dst   = 5'd3;
      tick();
      clearInputs();
      issue_valid = 1'b1;
      issue_use1  = 1'b1;
      issue_ra1   = 5'd3;
      repeat (4) tick();
      checkOutput("midrst pre stall", stall_cycles, 32'd10);
      checkOutput("midrst pre err",   32'(wb_err),  32'd1);
      checkOutput("midrst pre busy",  busy,         32'h8);
      issue_wen = 1'b1;
      issue_dst = 5'd8;
      wb_valid  = 1'b1;
      wb_dst    = 5'd3;
      reset     = 1'b0;
      tick();
      reset = 1'b1;
      clearInputs();
      #1;
      checkOutput("midrst busy",  busy,             32'h0);
      checkOutput("midrst stall", stall_cycles,     32'd0);
      checkOutput("midrst err",   32'(wb_err),      32'd0);
      checkOutput("midrst ready", 32'(issue_ready), 32'd1);

      // Flush suppresses the writeback error; a later bad writeback sets it again.
      flush    = 1'b1;
      wb_valid = 1'b1;
      wb_dst   = 5'd12;
      tick();
      clearInputs();
      #1;
      checkOutput("flush no err", 32'(wb_err), 32'd0);
      wb_valid = 1'b1;
      wb_dst   = 5'd12;
      tick();
      clearInputs();
      #1;
      checkOutput("err after reset", 32'(wb_err), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
